// File: rtl/lector_display_7seg_pkg.sv
// Shared types and 7-segment patterns for the display
// loopback reader.
package pkg_display;

  localparam int NUM_DIGITOS = 3;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Patterns in {g,f,e,d,c,b,a} order, active-high
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_9_ALT = 7'h67;

endpackage

// File: rtl/lector_display_7seg_decodificador.sv
// Combinational 7-segment to BCD decoder; anything outside
// the decimal set yields 4'hF and flags invalido.
module decodificador_7seg_bcd
  import pkg_display::*;
(
  input  seg_t seg,
  output bcd_t bcd,
  output logic invalido
);

  always_comb begin
    bcd      = 4'hF;
    invalido = 1'b0;
    unique case (seg)
      SEG_0:            bcd = 4'd0;
      SEG_1:            bcd = 4'd1;
      SEG_2:            bcd = 4'd2;
      SEG_3:            bcd = 4'd3;
      SEG_4:            bcd = 4'd4;
      SEG_5:            bcd = 4'd5;
      SEG_6:            bcd = 4'd6;
      SEG_7:            bcd = 4'd7;
      SEG_8:            bcd = 4'd8;
      SEG_9, SEG_9_ALT: bcd = 4'd9;
      default:          invalido = 1'b1;
    endcase
  end

endmodule

// File: rtl/lector_display_7seg.sv
// Reads a scanned 3-digit 7-segment display back into BCD,
// one frame per full scan, with pattern and signal-loss flags.
module lector_display_7seg
  import pkg_display::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int SEG_ACT_LOW    = 0,
  parameter int AN_ACT_LOW     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segmentos_in,
  input  logic [2:0]  anodos_in,
  output logic [11:0] valor_bcd,
  output logic        valido,
  output logic        error_patron,
  output logic        sin_senal
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [9:0]    sync1, sync2;
  seg_t          seg_n, prev_seg;
  logic [2:0]    an_n, prev_an;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt;
  logic [2:0]    mask, mask_nx;
  logic          one_hot, multi_hot, same, cap, armed;
  bcd_t          bcd;
  logic          invalido;
  bcd_t          dig [NUM_DIGITOS];

  assign seg_n = (SEG_ACT_LOW != 0) ? ~sync2[6:0] : sync2[6:0];
  assign an_n  = (AN_ACT_LOW != 0)  ? ~sync2[9:7] : sync2[9:7];

  decodificador_7seg_bcd u_dec (
    .seg      (seg_n),
    .bcd      (bcd),
    .invalido (invalido)
  );

  // Capture fires on the cycle the stability count reaches its target
  always_comb begin
    one_hot   = (an_n == 3'b001) || (an_n == 3'b010)
             || (an_n == 3'b100);
    multi_hot = (an_n != 3'b000) && !one_hot;
    same      = ({an_n, seg_n} == {prev_an, prev_seg});
    cnt_nx    = '0;
    if (one_hot && same)
      cnt_nx = (cnt == C_MAX) ? C_MAX : cnt + 1'b1;
    cap     = one_hot && !armed && (cnt_nx == C_MAX);
    mask_nx = (mask == 3'b111) ? 3'b000 : mask;
    if (cap)
      mask_nx = mask_nx | an_n;
    else if (tcnt == T_LAST)
      mask_nx = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= '0;
      sync2        <= '0;
      prev_an      <= '0;
      prev_seg     <= '0;
      cnt          <= '0;
      tcnt         <= '0;
      armed        <= 1'b0;
      mask         <= '0;
      valor_bcd    <= '0;
      valido       <= 1'b0;
      error_patron <= 1'b0;
      sin_senal    <= 1'b0;
      for (int i = 0; i < NUM_DIGITOS; i++)
        dig[i] <= '0;
    end else begin
      sync1    <= {anodos_in, segmentos_in};
      sync2    <= sync1;
      prev_an  <= an_n;
      prev_seg <= seg_n;
      cnt      <= cnt_nx;
      mask     <= mask_nx;
      if (an_n != prev_an)
        armed <= 1'b0;
      else if (cap)
        armed <= 1'b1;
      for (int i = 0; i < NUM_DIGITOS; i++)
        if (cap && an_n[i])
          dig[i] <= bcd;
      valido <= (mask == 3'b111);
      if (mask == 3'b111)
        valor_bcd <= {dig[2], dig[1], dig[0]};
      if (multi_hot || (cap && invalido))
        error_patron <= 1'b1;
      if (cap) begin
        tcnt      <= '0;
        sin_senal <= 1'b0;
      end else if (tcnt != T_MAX) begin
        tcnt <= tcnt + 1'b1;
        if (tcnt == T_LAST)
          sin_senal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lector_display_7seg.sv
// Self-checking bench for lector_display_7seg: scans digits
// like the display driver and compares frames to a model.
module tb_lector_display_7seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segmentos_in;
  logic [2:0]  anodos_in;
  logic [11:0] valor_bcd;
  logic        valido;
  logic        error_patron;
  logic        sin_senal;

  int          checks = 0;
  int          errors = 0;
  int          vcount = 0;
  logic [11:0] last_val = '0;

  always #5 clk = ~clk;

  lector_display_7seg #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100),
    .SEG_ACT_LOW    (0),
    .AN_ACT_LOW     (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .segmentos_in (segmentos_in),
    .anodos_in    (anodos_in),
    .valor_bcd    (valor_bcd),
    .valido       (valido),
    .error_patron (error_patron),
    .sin_senal    (sin_senal)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [11:0] bcd3(input int h, t, u);
    return 12'(h * 256 + t * 16 + u);
  endfunction

  // Advance one clock; observe outputs 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (valido === 1'b1) begin
      vcount++;
      last_val = valor_bcd;
    end
  endtask

  task automatic slot(input logic [2:0] an, input logic [6:0] seg,
                      input int n);
    anodos_in    = an;
    segmentos_in = seg;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    slot(3'b000, 7'h00, n);
  endtask

  task automatic scan_num(input int h, t, u, input int len);
    slot(3'b001, seg_of(u), len);
    slot(3'b010, seg_of(t), len);
    slot(3'b100, seg_of(h), len);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    anodos_in    = 3'b000;
    segmentos_in = 7'h00;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valor_bcd !== 12'h000) begin
      errors++;
      $display("FAIL reset_valor: got %h want 000", valor_bcd);
    end
    checks++;
    if (valido !== 1'b0) begin
      errors++;
      $display("FAIL reset_valido: got %b want 0", valido);
    end
    checks++;
    if (error_patron !== 1'b0) begin
      errors++;
      $display("FAIL reset_error: got %b want 0", error_patron);
    end
    checks++;
    if (sin_senal !== 1'b0) begin
      errors++;
      $display("FAIL reset_sin: got %b want 0", sin_senal);
    end
  endtask

  task automatic test_scan_123();
    int v0;
    v0 = vcount;
    repeat (3) scan_num(1, 2, 3, 8);
    idle(12);
    checks++;
    if (vcount - v0 !== 3) begin
      errors++;
      $display("FAIL scan123_pulses: got %0d want 3", vcount - v0);
    end
    checks++;
    if (last_val !== 12'h123) begin
      errors++;
      $display("FAIL scan123_valor: got %h want 123", last_val);
    end
  endtask

  task automatic test_latency();
    int lat;
    lat = -1;
    slot(3'b001, seg_of(4), 8);
    slot(3'b010, seg_of(0), 8);
    anodos_in    = 3'b100;
    segmentos_in = seg_of(7);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (valido === 1'b1) begin
        lat = i;
        break;
      end
    end
    idle(12);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL latency: got %0d want 8", lat);
    end
    checks++;
    if (last_val !== 12'h704) begin
      errors++;
      $display("FAIL latency_valor: got %h want 704", last_val);
    end
  endtask

  task automatic test_random();
    int h, t, u, len, v0;
    logic [11:0] exp;
    for (int n = 0; n < 20; n++) begin
      h   = int'($urandom_range(9, 0));
      t   = int'($urandom_range(9, 0));
      u   = int'($urandom_range(9, 0));
      len = int'($urandom_range(12, 6));
      exp = bcd3(h, t, u);
      v0  = vcount;
      repeat (2) scan_num(h, t, u, len);
      idle(12);
      checks++;
      if (vcount - v0 !== 2 || last_val !== exp) begin
        errors++;
        $display("FAIL random_%0d: got %h x%0d want %h x2",
                 n, last_val, vcount - v0, exp);
      end
    end
    checks++;
    if (error_patron !== 1'b0) begin
      errors++;
      $display("FAIL random_error: got %b want 0", error_patron);
    end
  endtask

  task automatic test_glitch();
    slot(3'b001, seg_of(9), 2);
    slot(3'b001, seg_of(6), 8);
    slot(3'b010, seg_of(5), 8);
    slot(3'b100, seg_of(8), 8);
    idle(12);
    checks++;
    if (last_val !== 12'h856) begin
      errors++;
      $display("FAIL glitch: got %h want 856", last_val);
    end
  endtask

  task automatic test_multi_hot();
    int v0;
    checks++;
    if (error_patron !== 1'b0) begin
      errors++;
      $display("FAIL multihot_pre: got %b want 0", error_patron);
    end
    slot(3'b001, seg_of(7), 8);
    v0 = vcount;
    slot(3'b011, seg_of(1), 10);
    checks++;
    if (error_patron !== 1'b1 || vcount !== v0) begin
      errors++;
      $display("FAIL multihot: got err=%b pulses=%0d want 1 0",
               error_patron, vcount - v0);
    end
    slot(3'b010, seg_of(8), 8);
    slot(3'b100, seg_of(9), 8);
    idle(12);
    checks++;
    if (last_val !== 12'h987 || vcount - v0 !== 1) begin
      errors++;
      $display("FAIL multihot_mask: got %h x%0d want 987 x1",
               last_val, vcount - v0);
    end
  endtask

  task automatic test_bad_pattern();
    do_reset();
    slot(3'b001, 7'h49, 8);
    slot(3'b010, seg_of(2), 8);
    slot(3'b100, seg_of(1), 8);
    idle(12);
    checks++;
    if (last_val !== 12'h12F || error_patron !== 1'b1) begin
      errors++;
      $display("FAIL badpat: got %h err=%b want 12f 1",
               last_val, error_patron);
    end
    scan_num(4, 5, 6, 8);
    idle(12);
    checks++;
    if (last_val !== 12'h456 || error_patron !== 1'b1) begin
      errors++;
      $display("FAIL badpat_sticky: got %h err=%b want 456 1",
               last_val, error_patron);
    end
  endtask

  task automatic test_timeout();
    int v0;
    do_reset();
    repeat (99) tick();
    checks++;
    if (sin_senal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b want 0", sin_senal);
    end
    tick();
    checks++;
    if (sin_senal !== 1'b1) begin
      errors++;
      $display("FAIL timeout_100: got %b want 1", sin_senal);
    end
    repeat (50) tick();
    checks++;
    if (sin_senal !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: got %b want 1", sin_senal);
    end
    slot(3'b001, seg_of(5), 8);
    checks++;
    if (sin_senal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_resume: got %b want 0", sin_senal);
    end
    slot(3'b010, seg_of(3), 8);
    do_reset();
    v0 = vcount;
    slot(3'b100, seg_of(2), 8);
    idle(12);
    checks++;
    if (vcount !== v0 || valor_bcd !== 12'h000) begin
      errors++;
      $display("FAIL rst_midframe: got %h x%0d want 000 x0",
               valor_bcd, vcount - v0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    anodos_in    = 3'b000;
    segmentos_in = 7'h00;
    test_reset();
    test_scan_123();
    test_latency();
    test_random();
    test_glitch();
    test_multi_hot();
    test_bad_pattern();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
